msb_debounce_detect: RTL and testbench
======================================

Name: msb_debounce_detect

Overview:
Parametrised, registered successor to the combinational single-bit MSB detector. Each of CHANNELS lanes derives a raw level from a WIDTH-bit sample. The raw level is either the sample MSB or an unsigned threshold compare, selected at run time. Each lane then debounces its raw level over STABLE_CYCLES consecutive valid samples and drives a registered level output plus one-cycle rise and fall pulses. The block sits between sampled data buses and control/interrupt logic that must not react to single-sample glitches.

Parameters:
WIDTH, 4, sample width per channel in bits (>=1)
CHANNELS, 2, number of independent lanes (>=1)
STABLE_CYCLES, 3, consecutive differing valid samples required to change a level (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = MSB select, 1 = threshold compare
threshold  input  WIDTH  unsigned threshold, used when mode=1
in_valid  input  1  qualifies data_in this cycle (shared by all lanes)
data_in  input  CHANNELS*WIDTH  lane c occupies bits [c*WIDTH +: WIDTH]
data_out  output  CHANNELS  debounced level per lane
rise  output  CHANNELS  one-cycle pulse when a lane level goes 0->1
fall  output  CHANNELS  one-cycle pulse when a lane level goes 1->0

Behaviour:
- Reset (rst_n=0, asynchronous, including mid-operation): data_out=0, rise=0, fall=0, all counters=0. Outputs go low without waiting for a clock edge.
- Raw level per lane, combinational:
  - mode=0: raw = sample[WIDTH-1].
  - mode=1: raw = (sample >= threshold), unsigned compare.
- Per-lane counter: width max(1, $clog2(STABLE_CYCLES)), counts 0..STABLE_CYCLES-1, never wraps.
- Each rising edge with in_valid=1, per lane:
  - raw == level: cnt<=0, no pulse.
  - raw != level and cnt == STABLE_CYCLES-1: level<=raw, cnt<=0, rise (raw=1) or fall (raw=0) asserted for exactly this one registered cycle.
  - otherwise: cnt<=cnt+1, no pulse.
- Each rising edge with in_valid=0: cnt holds, level holds, rise=fall=0. Invalid cycles neither break nor advance a run.
- Latency:
  - level changes on the edge that samples the STABLE_CYCLES-th consecutive valid differing sample.
  - STABLE_CYCLES=1 gives a plain 1-cycle registered detector.
- rise and fall are mutually exclusive per lane and coincide with the data_out transition cycle.
- A run is broken by any valid sample equal to the current level; the count restarts from 0.
- mode or threshold changes take effect on the next sampled edge. Counters are not cleared; a run continues if the new raw level still differs from the current level.
- Lanes are fully independent; simultaneous events on several lanes are all reported in the same cycle.

Decomposition:
- Shared package msb_detect_pkg:
  - MODE_MSB=1'b0, MODE_THRESH=1'b1.
  - function cnt_width(int stable) returning max(1, $clog2(stable)).
- Sub-module msb_debounce_chan: one lane (raw select, counter, level, pulses).
- Top level instantiates CHANNELS copies via generate and slices data_in.

Test Plan (WIDTH=4, CHANNELS=2, STABLE_CYCLES=3 unless noted):
1. MSB mode, lane0=4'b1000, lane1=4'b0111, in_valid=1 for 3 edges -> data_out=2'b01 after 3rd edge; rise=2'b01 for that one cycle only; fall=0.
2. Glitch: lane0=1000 for 2 valid edges, then 0000 for 1 edge, then 1000 for 3 edges -> no change after the first two; data_out[0]=1 only after the final 3rd edge.
3. Valid gaps: lane0=1000 with in_valid pattern 1,0,1,1 -> data_out[0] rises on 4th edge; no pulse on the invalid cycle.
4. Threshold mode, threshold=5:
   - lane0=5 for 3 edges -> rise[0].
   - Then lane0=4 for 3 edges -> fall[0] pulse, data_out[0]=0.
   - threshold=0 with lane1=0 for 3 edges -> data_out[1]=1.
5. Reset mid-run: data_out=2'b11 with lane0 cnt=2, assert rst_n=0 between edges -> outputs 0 immediately. After release, 2 valid 0000 samples produce no fall pulse.
6. Build with STABLE_CYCLES=1, MSB mode: lane0 toggles 1000/0000 every edge -> data_out[0] follows 1 cycle later; rise/fall alternate every cycle.

Source files
------------

// File: rtl/msb_detect_pkg.sv
// Shared constants and helpers for the debounced MSB / threshold detector.
// Imported by the lane module and the top level.
package msb_detect_pkg;

  localparam logic MODE_MSB    = 1'b0;
  localparam logic MODE_THRESH = 1'b1;

  // Run counter width: enough bits for 0..stable-1, never narrower than one bit.
  function automatic int cnt_width(input int stable);
    int w;
    w = $clog2(stable);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/msb_debounce_detect_chan.sv
// One detector lane: raw level select, debounce run counter, registered level
// and single-cycle rise/fall pulses.
module msb_debounce_chan
  import msb_detect_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] threshold_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic          raw;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  assign raw = (mode_i == MODE_THRESH) ? (sample_i >= threshold_i) : sample_i[WIDTH-1];

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (valid_i) begin
      if (raw == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        level_d = raw;
        cnt_d   = '0;
        rise_d  = raw;
        fall_d  = ~raw;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/msb_debounce_detect.sv
// Multi-lane debounced level detector: each lane watches its own WIDTH-bit
// slice of data_in and reports a filtered level plus edge pulses.
module msb_debounce_detect
  import msb_detect_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int CHANNELS      = 2,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          threshold,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [CHANNELS-1:0]       data_out,
  output logic [CHANNELS-1:0]       rise,
  output logic [CHANNELS-1:0]       fall
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    msb_debounce_chan #(
      .WIDTH        (WIDTH),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode_i     (mode),
      .threshold_i(threshold),
      .valid_i    (in_valid),
      .sample_i   (data_in[c*WIDTH +: WIDTH]),
      .level_o    (data_out[c]),
      .rise_o     (rise[c]),
      .fall_o     (fall[c])
    );
  end

endmodule

// File: tb/tb_msb_debounce_detect.sv
// Scoreboard bench: two builds (STABLE_CYCLES=3 and =1) share the same stimulus;
// a behavioural model pushes expected outputs per edge, popped after the edge.
module tb_msb_debounce_detect;

  localparam int W = 4;
  localparam int C = 2;

  typedef struct packed {
    logic [C-1:0] d;
    logic [C-1:0] r;
    logic [C-1:0] f;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mode = 1'b0;
  logic [W-1:0]   threshold = '0;
  logic           in_valid = 1'b0;
  logic [C*W-1:0] data_in = '0;
  logic [C-1:0]   d3, r3, f3, d1, r1, f1;

  int errors = 0;
  int checks = 0;

  exp_t q3[$];
  exp_t q1[$];

  // Model state: index 0 tracks the STABLE_CYCLES=3 build, index 1 the =1 build.
  int m_lvl[2][C];
  int m_cnt[2][C];
  int m_stable[2] = '{3, 1};

  always #5 clk = ~clk;

  msb_debounce_detect #(.WIDTH(W), .CHANNELS(C), .STABLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .threshold(threshold), .in_valid(in_valid),
    .data_in(data_in), .data_out(d3), .rise(r3), .fall(f3)
  );

  msb_debounce_detect #(.WIDTH(W), .CHANNELS(C), .STABLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .threshold(threshold), .in_valid(in_valid),
    .data_in(data_in), .data_out(d1), .rise(r1), .fall(f1)
  );

  function automatic int raw_of(input logic m, input logic [W-1:0] thr, input logic [W-1:0] s);
    if (m) return (s >= thr) ? 1 : 0;
    return s[W-1] ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < C; c++) begin
        m_lvl[k][c] = 0;
        m_cnt[k][c] = 0;
      end
    q3.delete();
    q1.delete();
  endtask

  task automatic model_push();
    exp_t e;
    logic [W-1:0] s;
    int raw;
    for (int k = 0; k < 2; k++) begin
      e = '0;
      for (int c = 0; c < C; c++) begin
        s = data_in[c*W +: W];
        raw = raw_of(mode, threshold, s);
        if (in_valid) begin
          if (raw == m_lvl[k][c]) m_cnt[k][c] = 0;
          else if (m_cnt[k][c] >= m_stable[k] - 1) begin
            m_lvl[k][c] = raw;
            m_cnt[k][c] = 0;
            e.r[c] = (raw == 1);
            e.f[c] = (raw == 0);
          end else m_cnt[k][c]++;
        end
        e.d[c] = (m_lvl[k][c] == 1);
      end
      if (k == 0) q3.push_back(e); else q1.push_back(e);
    end
  endtask

  // Apply one cycle of stimulus, clock it, then pop and compare both builds.
  task automatic step(input logic m, input logic [W-1:0] thr, input logic v, input logic [C*W-1:0] din);
    exp_t e, o;
    mode = m; threshold = thr; in_valid = v; data_in = din;
    model_push();
    @(posedge clk);
    #1;
    checks++;
    if (q3.size() == 0) begin
      errors++;
      $display("FAIL sb3_empty: no expected entry at %0t", $time);
    end else begin
      e = q3.pop_front();
      o = '{d: d3, r: r3, f: f3};
      if (o !== e) begin
        errors++;
        $display("FAIL sb3 @%0t: got d=%b r=%b f=%b expected d=%b r=%b f=%b",
                 $time, o.d, o.r, o.f, e.d, e.r, e.f);
      end
    end
    checks++;
    if (q1.size() == 0) begin
      errors++;
      $display("FAIL sb1_empty: no expected entry at %0t", $time);
    end else begin
      e = q1.pop_front();
      o = '{d: d1, r: r1, f: f1};
      if (o !== e) begin
        errors++;
        $display("FAIL sb1 @%0t: got d=%b r=%b f=%b expected d=%b r=%b f=%b",
                 $time, o.d, o.r, o.f, e.d, e.r, e.f);
      end
    end
  endtask

  task automatic expect3(input string name, input logic [C-1:0] dv, input logic [C-1:0] rv, input logic [C-1:0] fv);
    checks++;
    if ({d3, r3, f3} !== {dv, rv, fv}) begin
      errors++;
      $display("FAIL %s: got d=%b r=%b f=%b expected d=%b r=%b f=%b", name, d3, r3, f3, dv, rv, fv);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({d3, r3, f3, d1, r1, f1} !== '0) begin
      errors++;
      $display("FAIL reset_async: got %b expected all zero", {d3, r3, f3, d1, r1, f1});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_msb_basic();
    test_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1, {4'b0111, 4'b1000});
    expect3("msb_rise", 2'b01, 2'b01, 2'b00);
    step(1'b0, 4'd0, 1'b1, {4'b0111, 4'b1000});
    expect3("msb_rise_once", 2'b01, 2'b00, 2'b00);
  endtask

  task automatic test_glitch();
    test_reset();
    step(1'b0, 4'd0, 1'b1, {4'b0000, 4'b1000});
    step(1'b0, 4'd0, 1'b1, {4'b0000, 4'b1000});
    expect3("glitch_hold", 2'b00, 2'b00, 2'b00);
    step(1'b0, 4'd0, 1'b1, {4'b0000, 4'b0000});
    step(1'b0, 4'd0, 1'b1, {4'b0000, 4'b1000});
    step(1'b0, 4'd0, 1'b1, {4'b0000, 4'b1000});
    expect3("glitch_restart", 2'b00, 2'b00, 2'b00);
    step(1'b0, 4'd0, 1'b1, {4'b0000, 4'b1000});
    expect3("glitch_rise", 2'b01, 2'b01, 2'b00);
  endtask

  task automatic test_valid_gaps();
    test_reset();
    step(1'b0, 4'd0, 1'b1, {4'b0000, 4'b1000});
    step(1'b0, 4'd0, 1'b0, {4'b0000, 4'b1000});
    expect3("gap_no_pulse", 2'b00, 2'b00, 2'b00);
    step(1'b0, 4'd0, 1'b1, {4'b0000, 4'b1000});
    step(1'b0, 4'd0, 1'b1, {4'b0000, 4'b1000});
    expect3("gap_rise", 2'b01, 2'b01, 2'b00);
  endtask

  task automatic test_threshold();
    test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 4'd5, 1'b1, {4'd0, 4'd5});
    expect3("thr_eq_rise", 2'b01, 2'b01, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b1, 4'd5, 1'b1, {4'd0, 4'd4});
    expect3("thr_below_fall", 2'b00, 2'b00, 2'b01);
    for (int i = 0; i < 3; i++) step(1'b1, 4'd0, 1'b1, {4'd0, 4'd4});
    checks++;
    if (d3[1] !== 1'b1) begin
      errors++;
      $display("FAIL thr_zero_lane1: got %b expected 1", d3[1]);
    end
  endtask

  // Mode change mid-run: counter carries over while the raw level still differs.
  task automatic test_mode_switch();
    test_reset();
    step(1'b0, 4'd0, 1'b1, {4'b0000, 4'b1000});
    step(1'b1, 4'd2, 1'b1, {4'b0000, 4'b0011});
    step(1'b1, 4'd2, 1'b1, {4'b0000, 4'b0011});
    expect3("mode_switch_run", 2'b01, 2'b01, 2'b00);
  endtask

  task automatic test_reset_midrun();
    test_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1, {4'b1000, 4'b1000});
    step(1'b0, 4'd0, 1'b1, {4'b1000, 4'b0000});
    step(1'b0, 4'd0, 1'b1, {4'b1000, 4'b0000});
    expect3("pre_reset_level", 2'b11, 2'b00, 2'b00);
    test_reset();
    step(1'b0, 4'd0, 1'b1, {4'b0000, 4'b0000});
    step(1'b0, 4'd0, 1'b1, {4'b0000, 4'b0000});
    expect3("post_reset_no_fall", 2'b00, 2'b00, 2'b00);
  endtask

  task automatic test_back_to_back();
    test_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 4'd0, 1'b1, (i % 2 == 0) ? {4'b0000, 4'b1000} : {4'b0000, 4'b0000});
      checks++;
      if ({d1[0], r1[0], f1[0]} !== ((i % 2 == 0) ? 3'b110 : 3'b001)) begin
        errors++;
        $display("FAIL toggle_s1 step %0d: got %b expected %b", i, {d1[0], r1[0], f1[0]},
                 (i % 2 == 0) ? 3'b110 : 3'b001);
      end
    end
  endtask

  task automatic test_random();
    test_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
      if (i == 150) test_reset();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_msb_basic();
    test_glitch();
    test_valid_gaps();
    test_threshold();
    test_mode_switch();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
